clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 126 ++++++++++++
 tb/tb_clk_period_meter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
//
// Measures the period of a slow signal, sig_in, in clock_in cycles. sig_in is
// asynchronous to clock_in, so it is synchronized first. The next rising edge
// after a start request opens the measurement, and the rising edge after that
// closes it.
//
// Parameters
//   WIDTH       - width of the period result and of the cycle counter
//   SYNC_STAGES - synchronizer depth on sig_in (2..4)
//   MAX_COUNT   - abort limit in clock_in cycles (must be < 2**WIDTH)
//
// Ports
//   clock_in - sole clock; all state changes on its rising edge
//   reset    - asynchronous, active-high reset
//   sig_in   - signal under measurement (asynchronous to clock_in)
//   start    - one-cycle request to begin a measurement (ignored while busy)
//   period   - last measured period in clock_in cycles (registered)
//   valid    - one-cycle pulse: period has just been updated
//   busy     - high while a measurement is in progress
//   timeout  - one-cycle pulse: measurement aborted, no edge within MAX_COUNT
module clk_period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 100_000_000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FIRST = 2'd1;
  localparam logic [1:0] MEASURE    = 2'd2;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   rise;
  logic [1:0]             state;
  logic [WIDTH-1:0]       counter;
  logic [WIDTH-1:0]       counter_inc;

  // Synchronizer chain followed by one extra flop used only for edge detection.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rise is high for exactly one cycle per synchronized low-to-high transition.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev;

  // Saturating increment. Normally the MAX_COUNT limit stops the counter first,
  // but the counter must never wrap even if the limit sits at the top of range.
  assign counter_inc = (counter == '1) ? counter : counter + ONE;

  // Measurement FSM. The counter is loaded with 1 on the opening edge, so on the
  // closing edge it already holds t1 - t0. A closing edge that lands in the same
  // cycle as the limit is treated as a valid result, not a timeout.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      period  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          // A rise in this same cycle is deliberately not taken as the first edge.
          if (start) begin
            state   <= WAIT_FIRST;
            counter <= '0;
            busy    <= 1'b1;
          end
        end
        WAIT_FIRST: begin
          if (rise) begin
            state   <= MEASURE;
            counter <= ONE;
          end else if (counter == MAX_CNT) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            counter <= counter_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            state  <= IDLE;
            busy   <= 1'b0;
            period <= counter;
            valid  <= 1'b1;
          end else if (counter == MAX_CNT) begin
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            counter <= counter_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//
// Self-checking bench for clk_period_meter. Two instances are used:
//   dut_a - MAX_COUNT = 50, used for the normal, timeout, busy and reset cases
//   dut_b - MAX_COUNT = 20, used for the case where the closing edge coincides
//           with the counter limit
// Each stimulus pushes its expected pulse (kind, period and optional cycle) into
// a per-instance queue. A monitor pops and compares whenever the DUT pulses
// valid or timeout.
module tb_clk_period_meter;

  localparam int WIDTH = 32;

  typedef struct {
    bit               is_to;
    logic [WIDTH-1:0] period;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_a = 1'b0;
  logic             start_a = 1'b0;
  logic             sig_b = 1'b0;
  logic             start_b = 1'b0;
  logic [WIDTH-1:0] period_a;
  logic [WIDTH-1:0] period_b;
  logic             valid_a, busy_a, timeout_a;
  logic             valid_b, busy_b, timeout_b;

  int   half_a = 0;
  int   half_b = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  clk_period_meter #(.WIDTH(WIDTH), .SYNC_STAGES(2), .MAX_COUNT(50)) dut_a (
    .clock_in(clk), .reset(reset), .sig_in(sig_a), .start(start_a),
    .period(period_a), .valid(valid_a), .busy(busy_a), .timeout(timeout_a)
  );

  clk_period_meter #(.WIDTH(WIDTH), .SYNC_STAGES(2), .MAX_COUNT(20)) dut_b (
    .clock_in(clk), .reset(reset), .sig_in(sig_b), .start(start_b),
    .period(period_b), .valid(valid_b), .busy(busy_b), .timeout(timeout_b)
  );

  // 10 ns clock and a free-running cycle index used to time the timeout pulse.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Square-wave generators: sig toggles every half cycles (period 2*half);
  // half == 0 holds the signal low.
  initial begin
    int cnt_a = 0;
    forever begin
      @(negedge clk);
      if (half_a == 0) begin
        sig_a = 1'b0;
        cnt_a = 0;
      end else begin
        cnt_a++;
        if (cnt_a >= half_a) begin
          cnt_a = 0;
          sig_a = ~sig_a;
        end
      end
    end
  end

  initial begin
    int cnt_b = 0;
    forever begin
      @(negedge clk);
      if (half_b == 0) begin
        sig_b = 1'b0;
        cnt_b = 0;
      end else begin
        cnt_b++;
        if (cnt_b >= half_b) begin
          cnt_b = 0;
          sig_b = ~sig_b;
        end
      end
    end
  end

  // Scoreboard monitor for dut_a.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (valid_a || timeout_a)) begin
        check_output("a_valid_timeout_exclusive", 64'(valid_a & timeout_a), 0);
        check_output("a_busy_low_on_pulse", 64'(busy_a), 0);
        if (q_a.size() == 0) begin
          fail_now("a_unexpected_pulse", $sformatf("got valid=%0d timeout=%0d period=%0d, expected no pulse",
                   valid_a, timeout_a, period_a));
        end else begin
          e = q_a.pop_front();
          check_output("a_pulse_kind_timeout", 64'(timeout_a), 64'(e.is_to));
          check_output("a_period", 64'(period_a), 64'(e.period));
          if (e.cyc >= 0) check_output("a_pulse_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Scoreboard monitor for dut_b.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (valid_b || timeout_b)) begin
        check_output("b_valid_timeout_exclusive", 64'(valid_b & timeout_b), 0);
        check_output("b_busy_low_on_pulse", 64'(busy_b), 0);
        if (q_b.size() == 0) begin
          fail_now("b_unexpected_pulse", $sformatf("got valid=%0d timeout=%0d period=%0d, expected no pulse",
                   valid_b, timeout_b, period_b));
        end else begin
          e = q_b.pop_front();
          check_output("b_pulse_kind_timeout", 64'(timeout_b), 64'(e.is_to));
          check_output("b_period", 64'(period_b), 64'(e.period));
        end
      end
    end
  end

  // One-cycle start pulse; returns the cycle index just after the sampling edge.
  task automatic apply_stimulus_a(output int sampled);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    sampled = cyc;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic apply_stimulus_b();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic push_a(input bit is_to, input int per, input int at_cyc);
    exp_t e;
    e.is_to  = is_to;
    e.period = WIDTH'(per);
    e.cyc    = at_cyc;
    q_a.push_back(e);
  endtask

  task automatic drain_a(input int budget);
    int n = 0;
    while (q_a.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0) begin
      fail_now("a_drain_bound", $sformatf("got %0d pending results after %0d cycles, expected 0", q_a.size(), budget));
      q_a.delete();
    end
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    while (q_b.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_b.size() != 0) begin
      fail_now("b_drain_bound", $sformatf("got %0d pending results after %0d cycles, expected 0", q_b.size(), budget));
      q_b.delete();
    end
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   s;
    int   n;
    logic last;
    exp_t eb;

    // Reset behaviour: outputs low while reset is held and right after release.
    #50;
    check_output("rst_hold_period", 64'(period_a), 0);
    check_output("rst_hold_busy", 64'(busy_a), 0);
    check_output("rst_hold_valid", 64'(valid_a), 0);
    check_output("rst_hold_timeout", 64'(timeout_a), 0);
    #50;
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_release_period", 64'(period_a), 0);
    check_output("rst_release_busy", 64'(busy_a), 0);
    check_output("rst_release_valid", 64'(valid_a), 0);
    check_output("rst_release_timeout", 64'(timeout_a), 0);

    // Period 20 (10 high / 10 low).
    $display("[TB] period 20 measurement");
    half_a = 10;
    repeat (30) @(negedge clk);
    push_a(1'b0, 20, -1);
    apply_stimulus_a(s);
    check_output("a_busy_after_start", 64'(busy_a), 1);
    drain_a(100);
    @(negedge clk);
    check_output("a_busy_after_valid", 64'(busy_a), 0);
    check_output("a_period_hold_20", 64'(period_a), 20);

    // Signal held low: timeout 51 cycles after start, period unchanged.
    $display("[TB] timeout with sig held low");
    half_a = 0;
    repeat (10) @(negedge clk);
    apply_stimulus_a(s);
    push_a(1'b1, 20, s + 51);
    drain_a(100);
    @(negedge clk);
    check_output("a_period_after_timeout", 64'(period_a), 20);
    check_output("a_busy_after_timeout", 64'(busy_a), 0);

    // Repeated start while busy, period 8: exactly one result.
    $display("[TB] repeated start while busy");
    half_a = 4;
    repeat (20) @(negedge clk);
    push_a(1'b0, 8, -1);
    apply_stimulus_a(s);
    for (int k = 0; k < 3; k++) begin
      check_output("a_busy_before_extra_start", 64'(busy_a), 1);
      apply_stimulus_a(s);
    end
    drain_a(100);
    repeat (30) @(negedge clk);
    check_output("a_idle_after_single_result", 64'(busy_a), 0);
    check_output("a_period_hold_8", 64'(period_a), 8);

    // Reset in the middle of a period-40 measurement, then a clean run.
    $display("[TB] reset mid-measurement");
    half_a = 20;
    repeat (45) @(negedge clk);
    apply_stimulus_a(s);
    n = 0;
    @(posedge clk);
    last = sig_a;
    @(posedge clk);
    while (!(!last && sig_a) && n < 100) begin
      last = sig_a;
      @(posedge clk);
      n++;
    end
    if (n >= 100) fail_now("a_wait_sig_rise", "got no sig_a rise within 100 cycles, expected one");
    repeat (18) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("a_midrst_busy", 64'(busy_a), 0);
    check_output("a_midrst_valid", 64'(valid_a), 0);
    check_output("a_midrst_timeout", 64'(timeout_a), 0);
    check_output("a_midrst_period", 64'(period_a), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check_output("a_idle_after_midrst", 64'(busy_a), 0);
    push_a(1'b0, 40, -1);
    apply_stimulus_a(s);
    drain_a(200);

    // Closing edge coincides with counter == MAX_COUNT (20): valid, no timeout.
    $display("[TB] edge at counter limit");
    half_b = 10;
    for (int k = 0; k < 2; k++) begin
      repeat (25 + 7 * k) @(negedge clk);
      eb.is_to  = 1'b0;
      eb.period = WIDTH'(20);
      eb.cyc    = -1;
      q_b.push_back(eb);
      apply_stimulus_b();
      drain_b(100);
      @(negedge clk);
      check_output("b_busy_after_limit_edge", 64'(busy_b), 0);
    end

    repeat (10) @(negedge clk);
    check_output("a_queue_empty", 64'(q_a.size()), 0);
    check_output("b_queue_empty", 64'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
